// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, round-robin replacement,
// single-cycle flush and hit/miss counters.
module icache_assoc #(
    parameter int unsigned NSETS           = 8,
    parameter int unsigned NWAYS           = 2,
    parameter int unsigned WORDS_PER_BLOCK = 2,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             flush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int unsigned WOFF_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned WOFF_W    = (WOFF_BITS > 0) ? WOFF_BITS : 1;
    localparam int unsigned IDX_W     = $clog2(NSETS);
    localparam int unsigned PTR_W     = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int unsigned TAG_LSB   = 2 + WOFF_BITS + IDX_W;
    localparam int unsigned TAG_W     = 32 - TAG_LSB;
    localparam logic [31:0] BLK_MASK  = 32'(WORDS_PER_BLOCK * 4 - 1);

    typedef enum logic [0:0] {StLookup, StFill} state_e;

    state_e             state_q, state_d;
    logic [NWAYS-1:0]   valid_q [NSETS];
    logic [TAG_W-1:0]   tag_q   [NSETS][NWAYS];
    logic [31:0]        data_q  [NSETS][NWAYS][WORDS_PER_BLOCK];
    logic [PTR_W-1:0]   rr_q    [NSETS];
    logic [31:0]        stage_q [WORDS_PER_BLOCK];
    logic [31:0]        base_q;
    logic [WOFF_W-1:0]  fill_k_q;
    logic [PTR_W-1:0]   victim_q;
    logic               victim_by_ptr_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [WOFF_W-1:0]  req_woff;
    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               tag_hit, free_found;
    logic [PTR_W-1:0]   hit_way, free_way;
    logic               lookup, do_hit, do_miss, beat, last_beat;

    assign req_woff = WOFF_W'((imemaddr >> 2) & 32'(WORDS_PER_BLOCK - 1));
    assign req_idx  = IDX_W'(imemaddr >> (2 + WOFF_BITS));
    assign req_tag  = imemaddr[31:TAG_LSB];
    assign fill_idx = IDX_W'(base_q >> (2 + WOFF_BITS));
    assign fill_tag = base_q[31:TAG_LSB];

    always_comb begin
        tag_hit    = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < NWAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                tag_hit = 1'b1;
                hit_way = PTR_W'(w);
            end
            if (!valid_q[req_idx][w] && !free_found) begin
                free_found = 1'b1;
                free_way   = PTR_W'(w);
            end
        end
    end

    // Reset and flush both suppress any lookup or fill beat in the current cycle.
    assign lookup    = (state_q == StLookup) && !RST && !flush;
    assign do_hit    = lookup && imemREN && tag_hit;
    assign do_miss   = lookup && imemREN && !tag_hit;
    assign beat      = (state_q == StFill) && !RST && !flush && !iwait;
    assign last_beat = beat && (fill_k_q == WOFF_W'(WORDS_PER_BLOCK - 1));

    assign ihit       = do_hit;
    assign imemload   = do_hit ? data_q[req_idx][hit_way][req_woff] : '0;
    assign iREN       = (state_q == StFill) && !RST;
    assign iaddr      = iREN ? (base_q + (32'(fill_k_q) << 2)) : '0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLookup: if (do_miss) state_d = StFill;
            StFill:   if (last_beat) state_d = StLookup;
            default:  state_d = StLookup;
        endcase
        if (flush) state_d = StLookup;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StLookup;
            fill_k_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < NSETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            if (do_hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (do_miss) begin
                miss_cnt_q      <= miss_cnt_q + CNT_W'(1);
                base_q          <= imemaddr & ~BLK_MASK;
                victim_q        <= free_found ? free_way : rr_q[req_idx];
                victim_by_ptr_q <= !free_found;
                fill_k_q        <= '0;
            end
            if (beat) fill_k_q <= last_beat ? '0 : fill_k_q + WOFF_W'(1);
            if (last_beat) begin
                valid_q[fill_idx][victim_q] <= 1'b1;
                tag_q[fill_idx][victim_q]   <= fill_tag;
                if (victim_by_ptr_q && NWAYS > 1) rr_q[fill_idx] <= rr_q[fill_idx] + PTR_W'(1);
            end
            if (flush) begin
                fill_k_q <= '0;
                for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
            end
        end
    end

    // The final word is taken straight from iload so the block commits on its last beat.
    always_ff @(posedge CLK) begin
        if (beat) stage_q[fill_k_q] <= iload;
        if (last_beat) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                data_q[fill_idx][victim_q][i] <= (WOFF_W'(i) == fill_k_q) ? iload : stage_q[i];
            end
        end
    end
endmodule
